// File: rtl/cordic_polar_to_cart_if.sv
// Stream bundle between a polar (magnitude/angle) source, the polar-to-cartesian
// CORDIC stage and the cartesian consumer.
interface cordic_polar_to_cart_if #(
    parameter int DATA_WIDTH_IN  = 11,
    parameter int ANGLE_WIDTH    = 9,
    parameter int DATA_WIDTH_OUT = 12
);
    logic                             in_valid;
    logic                             in_ready;
    logic [DATA_WIDTH_IN-1:0]         mag_in;
    logic [ANGLE_WIDTH-1:0]           angle_in;
    logic                             out_valid;
    logic                             out_ready;
    logic signed [DATA_WIDTH_OUT-1:0] x_out;
    logic signed [DATA_WIDTH_OUT-1:0] y_out;

    modport slave (
        input  in_valid, mag_in, angle_in, out_ready,
        output in_ready, out_valid, x_out, y_out
    );

    modport master (
        output in_valid, mag_in, angle_in, out_ready,
        input  in_ready, out_valid, x_out, y_out
    );
endinterface

// File: rtl/cordic_polar_to_cart.sv
// Rotation-mode CORDIC: unsigned magnitude + integer-degree angle -> signed x = mag*cos, y = mag*sin.
// Latency ITER+2 cycles from accept to out_valid, one sample per cycle.
// Global stall: while out_valid & ~out_ready every stage holds and in_ready drops.
module cordic_polar_to_cart #(
    parameter int DATA_WIDTH_IN  = 11,
    parameter int ANGLE_WIDTH    = 9,
    parameter int DATA_WIDTH_OUT = 12,
    parameter int ITER           = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cordic_polar_to_cart_if.slave  io
);
    localparam int XW = DATA_WIDTH_IN + 2;
    localparam int PW = XW + 17;

    // atan(2^-i) in degrees, Q16
    localparam logic signed [31:0] ATAN [16] = '{
        32'sd2949120, 32'sd1740992, 32'sd919872, 32'sd466944,
        32'sd234368,  32'sd117312,  32'sd58688,  32'sd29312,
        32'sd14656,   32'sd7360,    32'sd3648,   32'sd1856,
        32'sd896,     32'sd448,     32'sd256,    32'sd128
    };

    // 1/gain = 0.607253 in Q16
    localparam logic signed [PW-1:0] K_SCALE = PW'(39796);

    logic stall;
    assign stall       = io.out_valid & ~io.out_ready;
    assign io.in_ready = ~stall;

    logic                 vld [ITER+1];
    logic signed [XW-1:0] xs  [ITER+1];
    logic signed [XW-1:0] ys  [ITER+1];
    logic signed [31:0]   zs  [ITER];

    // ---------------- angle reduction / quadrant fold ----------------
    logic [ANGLE_WIDTH-1:0] ang_raw;
    logic [31:0]            ang_ext;
    logic [31:0]            ang_red;
    logic signed [31:0]     z_deg;
    logic signed [XW-1:0]   mag_s;
    logic signed [XW-1:0]   x_init;

    assign ang_raw = io.angle_in;

    always_comb begin
        ang_ext = 32'(ang_raw);
        ang_red = (ang_ext >= 32'd360) ? ang_ext - 32'd360 : ang_ext;
        mag_s   = $signed({2'b00, io.mag_in});
        x_init  = mag_s;
        z_deg   = $signed(ang_red);
        // fold the left half-plane onto [-90,90] by negating x and shifting by 180
        if (ang_red > 32'd270) begin
            z_deg = $signed(ang_red) - 32'sd360;
        end else if (ang_red > 32'd90) begin
            x_init = -mag_s;
            z_deg  = $signed(ang_red) - 32'sd180;
        end
    end

    logic                 p_vld;
    logic signed [XW-1:0] p_x;
    logic signed [31:0]   p_z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_vld <= 1'b0;
            p_x   <= '0;
            p_z   <= '0;
        end else if (!stall) begin
            // in_ready is high whenever we are not stalled, so in_valid alone marks an accept
            p_vld <= io.in_valid;
            p_x   <= x_init;
            p_z   <= z_deg <<< 16;
        end
    end

    assign vld[0] = p_vld;
    assign xs[0]  = p_x;
    assign ys[0]  = '0;
    assign zs[0]  = p_z;

    // ---------------- micro-rotations ----------------
    for (genvar i = 0; i < ITER; i++) begin : g_rot
        logic                 v_q;
        logic signed [XW-1:0] x_q;
        logic signed [XW-1:0] y_q;
        logic                 rot_pos;

        assign rot_pos = ~zs[i][31];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                x_q <= '0;
                y_q <= '0;
            end else if (!stall) begin
                v_q <= vld[i];
                x_q <= rot_pos ? xs[i] - (ys[i] >>> i) : xs[i] + (ys[i] >>> i);
                y_q <= rot_pos ? ys[i] + (xs[i] >>> i) : ys[i] - (xs[i] >>> i);
            end
        end

        assign vld[i+1] = v_q;
        assign xs[i+1]  = x_q;
        assign ys[i+1]  = y_q;

        // the residual angle after the final rotation is never consumed
        if (i < ITER-1) begin : g_z
            logic signed [31:0] z_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    z_q <= '0;
                end else if (!stall) begin
                    z_q <= rot_pos ? zs[i] - ATAN[i] : zs[i] + ATAN[i];
                end
            end

            assign zs[i+1] = z_q;
        end
    end

    // ---------------- gain compensation ----------------
    logic signed [PW-1:0] x_ext;
    logic signed [PW-1:0] y_ext;
    logic signed [PW-1:0] x_prod;
    logic signed [PW-1:0] y_prod;

    assign x_ext  = {{(PW-XW){xs[ITER][XW-1]}}, xs[ITER]};
    assign y_ext  = {{(PW-XW){ys[ITER][XW-1]}}, ys[ITER]};
    assign x_prod = x_ext * K_SCALE;
    assign y_prod = y_ext * K_SCALE;

    logic                             o_vld;
    logic signed [DATA_WIDTH_OUT-1:0] o_x;
    logic signed [DATA_WIDTH_OUT-1:0] o_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_vld <= 1'b0;
            o_x   <= '0;
            o_y   <= '0;
        end else if (!stall) begin
            o_vld <= vld[ITER];
            o_x   <= DATA_WIDTH_OUT'(x_prod >>> 16);
            o_y   <= DATA_WIDTH_OUT'(y_prod >>> 16);
        end
    end

    assign io.out_valid = o_vld;
    assign io.x_out     = o_x;
    assign io.y_out     = o_y;
endmodule

// File: tb/tb_cordic_polar_to_cart.sv
// Directed and swept checks of the polar-to-cartesian CORDIC against hand values and a real-valued model.
module tb_cordic_polar_to_cart;
    localparam int  DW_IN  = 11;
    localparam int  AW     = 9;
    localparam int  DW_OUT = 12;
    localparam int  ITER   = 8;
    localparam real PI     = 3.14159265358979;
    localparam real ATAN_LAST_DEG = 29312.0 / 65536.0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cordic_polar_to_cart_if #(.DATA_WIDTH_IN(DW_IN), .ANGLE_WIDTH(AW), .DATA_WIDTH_OUT(DW_OUT)) bus ();

    cordic_polar_to_cart #(
        .DATA_WIDTH_IN (DW_IN),
        .ANGLE_WIDTH   (AW),
        .DATA_WIDTH_OUT(DW_OUT),
        .ITER          (ITER)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
        int d;
        n_vec++;
        d = obs - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    function automatic int model(input int mag, input int ang, input bit is_y);
        real r;
        r = is_y ? mag * $sin(ang * PI / 180.0) : mag * $cos(ang * PI / 180.0);
        return $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
    endfunction

    // spec accuracy bound plus half an LSB for rounding the reference
    function automatic int tol_rule(input int mag);
        return $rtoi($ceil(mag * $tan(ATAN_LAST_DEG * PI / 180.0) + 3.5));
    endfunction

    task automatic send_one(input int mag, input int ang, output int xo, output int yo, output int lat);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.mag_in    = DW_IN'(mag);
        bus.angle_in  = AW'(ang);
        bus.out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        #1 bus.in_valid = 1'b0;
        xo = 0;
        yo = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (bus.out_valid) break;
            @(posedge clk);
            lat++;
        end
        if (bus.out_valid) begin
            xo = bus.x_out;
            yo = bus.y_out;
        end else begin
            lat = -1;
        end
    endtask

    typedef struct { int mag; int ang; int ex; int ey; int tol; } dvec_t;
    dvec_t dvecs [15] = '{
        '{1000,   0, 1000,     0, 10}, '{1000,  90,    0,  1000, 10},
        '{1000, 180, -1000,    0, 10}, '{1000, 270,    0, -1000, 10},
        '{1000,  45,  707,   707, 10}, '{1000, 225, -707,  -707, 10},
        '{1000, 135, -707,   707, 10}, '{1000, 400,  766,   643, 10},
        '{2047,   0, 2047,     0, 19}, '{1000,  91,  -17,  1000, 10},
        '{1000, 271,   17, -1000, 10}, '{   0,   0,    0,     0,  0},
        '{   0, 137,    0,     0,  0}, '{   0, 300,    0,     0,  0},
        '{   0, 511,    0,     0,  0}
    };
    int sweep_mag [4] = '{1, 255, 1000, 2047};

    int xo, yo, lat;
    int sent, rcvd, cyc, px, py, e, m, a, quiet_hits;
    bit prev_stall;
    int exp_q [$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.mag_in    = '0;
        bus.angle_in  = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_x", bus.x_out, 0);
        check("rst_y", bus.y_out, 0);
        check("rst_in_ready", bus.in_ready, 1);
        rst_n = 1'b1;

        // directed points: axes, diagonals, wrap above 360, full scale, zero, quadrant edges
        foreach (dvecs[k]) begin
            send_one(dvecs[k].mag, dvecs[k].ang, xo, yo, lat);
            check($sformatf("dir_lat_m%0d_a%0d", dvecs[k].mag, dvecs[k].ang), lat, ITER + 2);
            check($sformatf("dir_x_m%0d_a%0d", dvecs[k].mag, dvecs[k].ang), xo, dvecs[k].ex, dvecs[k].tol);
            check($sformatf("dir_y_m%0d_a%0d", dvecs[k].mag, dvecs[k].ang), yo, dvecs[k].ey, dvecs[k].tol);
        end

        // back-to-back stream with random backpressure
        sent = 0; rcvd = 0; cyc = 0; prev_stall = 1'b0; px = 0; py = 0;
        while (rcvd < 64 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (prev_stall) begin
                check("bp_hold_valid", bus.out_valid, 1);
                check("bp_hold_x", bus.x_out, px);
                check("bp_hold_y", bus.y_out, py);
            end
            bus.out_ready = ($urandom_range(0, 1) == 1);
            bus.in_valid  = (sent < 64);
            bus.mag_in    = DW_IN'(500 + sent * 20);
            bus.angle_in  = AW'((sent * 37) % 512);
            #1;
            check("bp_in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("bp_spurious_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    m = e / 1024;
                    a = e % 1024;
                    check($sformatf("bp_x_%0d", rcvd), bus.x_out, model(m, a, 1'b0), tol_rule(m));
                    check($sformatf("bp_y_%0d", rcvd), bus.y_out, model(m, a, 1'b1), tol_rule(m));
                end
                rcvd++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            px = bus.x_out;
            py = bus.y_out;
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back((500 + sent * 20) * 1024 + (sent * 37) % 512);
                sent++;
            end
        end
        bus.in_valid = 1'b0;
        check("bp_count", rcvd, 64);
        check("bp_leftover", exp_q.size(), 0);

        // reset with six samples in flight
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.in_valid = 1'b1;
            bus.mag_in   = DW_IN'(800);
            bus.angle_in = AW'(10 * k);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_x", bus.x_out, 0);
        check("mid_rst_y", bus.y_out, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        quiet_hits = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.out_valid) quiet_hits++;
        end
        check("post_rst_stale", quiet_hits, 0);
        send_one(1000, 60, xo, yo, lat);
        check("post_rst_lat", lat, ITER + 2);
        check("post_rst_x", xo, 500, 10);
        check("post_rst_y", yo, 866, 10);

        // full angle sweep at four magnitudes against the real-valued model
        foreach (sweep_mag[k]) begin
            for (int ang = 0; ang < 512; ang++) begin
                send_one(sweep_mag[k], ang, xo, yo, lat);
                check($sformatf("sw_lat_m%0d_a%0d", sweep_mag[k], ang), lat, ITER + 2);
                check($sformatf("sw_x_m%0d_a%0d", sweep_mag[k], ang), xo,
                      model(sweep_mag[k], ang, 1'b0), tol_rule(sweep_mag[k]));
                check($sformatf("sw_y_m%0d_a%0d", sweep_mag[k], ang), yo,
                      model(sweep_mag[k], ang, 1'b1), tol_rule(sweep_mag[k]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
